// File: rtl/dmem_pkg.sv
// Shared types and the address-legality rule for the data-memory arbiter.
// Pure declarations: no latency and no flow control of its own.
package dmem_pkg;

  localparam logic [31:0] IO_ADDR_C = 32'h7FFF_FFFC;

  typedef enum logic {IDLE, SERVE} dmem_state_t;

  typedef logic req_id_t;

  // Word-aligned inside the byte array, or the memory-mapped IO word.
  function automatic logic is_legal(input logic [31:0] addr, input logic [31:0] mem_bytes);
    is_legal = ((addr[1:0] == 2'b00) && (addr <= mem_bytes - 32'd4)) || (addr == IO_ADDR_C);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a burst cap; sel/valid are combinational from req.
// State moves only on advance; a requester that is not selected simply keeps waiting.
module rr_arbiter2
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       CLK,
  input  logic       nReset,
  input  logic [1:0] req,
  input  logic       advance,
  output req_id_t    sel,
  output logic       valid
);

  localparam logic [3:0] MAX_C = 4'(MAX_BURST);

  req_id_t    last_q, last_d;
  logic [3:0] burst_q, burst_d;

  always_comb begin
    valid   = |req;
    sel     = last_q;
    last_d  = last_q;
    burst_d = burst_q;

    // A zero count means no contended burst is running, so a tie goes to the other side.
    if (req == 2'b01) begin
      sel = 1'b0;
    end else if (req == 2'b10) begin
      sel = 1'b1;
    end else if (req == 2'b11) begin
      sel = ((burst_q != 4'd0) && (burst_q < MAX_C)) ? last_q : ~last_q;
    end

    if (advance && valid) begin
      last_d = sel;
      if (!req[~sel]) begin
        burst_d = 4'd0;
      end else if (sel == last_q) begin
        burst_d = burst_q + 4'd1;
      end else begin
        burst_d = 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      last_q  <= 1'b1;
      burst_q <= 4'd0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the load/store unit and the debug loader.
// Latency: req in N, gnt in N+1, registered response in N+2; losers hold req until granted.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [31:0] IO_ADDR   = IO_ADDR_C,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        CLK,
  input  logic        nReset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] A0,
  input  logic [31:0] A1,
  input  logic [31:0] WD0,
  input  logic [31:0] WD1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] RDo,
  output logic        err,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        WE,
  input  logic [31:0] RD
);

  dmem_state_t state_q, state_d;
  req_id_t     sel_q, sel_d;
  req_id_t     arb_sel;
  logic        arb_valid;
  logic        advance;

  logic [1:0]  gnt;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [31:0] rdo_q, rdo_d;
  logic        err_q, err_d;

  logic [31:0] a_sel, wd_sel;
  logic        we_sel, legal;

  assign advance = (state_q == IDLE);

  rr_arbiter2 #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .CLK     (CLK),
    .nReset  (nReset),
    .req     ({req1, req0}),
    .advance (advance),
    .sel     (arb_sel),
    .valid   (arb_valid)
  );

  assign a_sel  = sel_q ? A1  : A0;
  assign wd_sel = sel_q ? WD1 : WD0;
  assign we_sel = sel_q ? we1 : we0;
  assign legal  = is_legal(a_sel, 32'(MEM_BYTES)) || (a_sel == IO_ADDR);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    gnt      = 2'b00;
    A        = 32'd0;
    WD       = 32'd0;
    WE       = 1'b0;
    rvalid_d = 2'b00;
    rdo_d    = 32'd0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          sel_d   = arb_sel;
          state_d = SERVE;
        end
      end
      SERVE: begin
        // WE is purely combinational from state so an async reset aborts the write at once.
        gnt[sel_q]      = 1'b1;
        A               = a_sel;
        WD              = wd_sel;
        WE              = we_sel & legal;
        rvalid_d[sel_q] = 1'b1;
        rdo_d           = (legal && !we_sel) ? RD : 32'd0;
        err_d           = !legal;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      rvalid_q <= 2'b00;
      rdo_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rvalid_q <= rvalid_d;
      rdo_q    <= rdo_d;
      err_q    <= err_d;
    end
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign RDo     = rdo_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory with IO word, per-cycle transaction model,
// and directed accesses with hand-computed results.
module tb_dmem_arbiter;

  localparam logic [31:0] IO    = 32'h7FFF_FFFC;
  localparam logic [31:0] CPUIN = 32'hC0FF_EE01;
  localparam int          MAXB  = 4;

  logic        CLK = 1'b0;
  logic        nReset;
  logic [1:0]  req, we;
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [1:0]  gnt, rvalid;
  logic [31:0] RDo, A, WD, RD;
  logic        err, WE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  dmem_arbiter dut (
    .CLK(CLK), .nReset(nReset),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .A0(addr[0]), .A1(addr[1]), .WD0(wd[0]), .WD1(wd[1]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .rvalid0(rvalid[0]), .rvalid1(rvalid[1]),
    .RDo(RDo), .err(err), .A(A), .WD(WD), .WE(WE), .RD(RD)
  );

  // Memory block seen by the DUT.
  logic [7:0]  mem [1024];
  logic [31:0] cpuout;

  always @(posedge CLK) begin
    if (WE) begin
      if (A == IO) cpuout <= WD;
      else if (A <= 32'd1020) begin
        mem[A[9:0]]         <= WD[7:0];
        mem[A[9:0] + 10'd1] <= WD[15:8];
        mem[A[9:0] + 10'd2] <= WD[23:16];
        mem[A[9:0] + 10'd3] <= WD[31:24];
      end
    end
  end

  always_comb begin
    RD = 32'd0;
    if (A == IO) RD = CPUIN;
    else if (A <= 32'd1020)
      RD = {mem[A[9:0] + 10'd3], mem[A[9:0] + 10'd2], mem[A[9:0] + 10'd1], mem[A[9:0]]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] gold [1024];

  typedef struct {bit w; bit ow;} hent_t;
  hent_t hist[$];

  function automatic bit legal(input logic [31:0] a);
    return (((a % 4) == 0) && (a <= 32'd1020)) || (a == IO);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (a == IO) return CPUIN;
    return {gold[a + 3], gold[a + 2], gold[a + 1], gold[a]};
  endfunction

  // Length of the current contended run of wins by the latest winner.
  function automatic bit pick();
    bit last;
    int run;
    if (req != 2'b11) return req[1];
    last = (hist.size() == 0) ? 1'b1 : hist[hist.size() - 1].w;
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].w != last) break;
      if (!hist[i].ow) begin
        run = 0;
        break;
      end
      run++;
    end
    return (run > 0 && run < MAXB) ? last : ~last;
  endfunction

  bit          m_busy = 0, m_pend = 0, m_sel = 0, m_psel = 0, m_perr = 0;
  logic [31:0] m_prdo = 0;

  always @(negedge CLK) begin
    logic [1:0]  e_gnt, e_rv;
    logic [31:0] e_a, e_wd, e_rdo;
    logic        e_we, e_err, lg;
    e_gnt = 0; e_rv = 0; e_a = 0; e_wd = 0; e_rdo = 0; e_we = 0; e_err = 0;
    if (!nReset) begin
      m_busy = 0; m_pend = 0;
      hist.delete();
    end else begin
      if (m_pend) begin
        e_rv[m_psel] = 1'b1;
        e_rdo = m_prdo;
        e_err = m_perr;
      end
      m_pend = 0;
      if (m_busy) begin
        e_gnt[m_sel] = 1'b1;
        e_a  = addr[m_sel];
        e_wd = wd[m_sel];
        lg   = legal(e_a);
        e_we = we[m_sel] & lg;
        m_pend = 1; m_psel = m_sel; m_perr = !lg;
        m_prdo = (lg && !we[m_sel]) ? gold_rd(e_a) : 32'd0;
        if (e_we && e_a != IO) begin
          gold[e_a]     = e_wd[7:0];
          gold[e_a + 1] = e_wd[15:8];
          gold[e_a + 2] = e_wd[23:16];
          gold[e_a + 3] = e_wd[31:24];
        end
        m_busy = 0;
      end else if (req != 2'b00) begin
        m_sel = pick();
        hist.push_back('{w: m_sel, ow: req[~m_sel]});
        m_busy = 1;
      end
    end
    chk("gnt",    {30'd0, gnt},    {30'd0, e_gnt});
    chk("rvalid", {30'd0, rvalid}, {30'd0, e_rv});
    chk("RDo",    RDo,             e_rdo);
    chk("err",    {31'd0, err},    {31'd0, e_err});
    chk("A",      A,               e_a);
    chk("WD",     WD,              e_wd);
    chk("WE",     {31'd0, WE},     {31'd0, e_we});
  end

  // ---------------- directed stimulus ----------------
  task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic we_g, output logic [31:0] a_g,
                        output logic [31:0] rdo, output logic e);
    bit got;
    @(posedge CLK); #1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wd[p] = d;
    got = 0; we_g = 0; a_g = 0; rdo = 0; e = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (gnt[p]) begin
        got = 1; we_g = WE; a_g = A;
      end
    end
    chk("access_gnt_seen", {31'd0, got}, 32'd1);
    @(posedge CLK); #1;
    req[p] = 1'b0;
    @(negedge CLK);
    chk("access_rvalid", {31'd0, rvalid[p]}, 32'd1);
    rdo = RDo; e = err;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    nReset = 1'b0; req = 2'b00;
    @(posedge CLK); #1;
    nReset = 1'b1;
  endtask

  logic        weg, e;
  logic [31:0] ag, rdo;
  int          order[$];
  int          g0_cyc, g1_cyc;
  bit          seen;
  int          exp_order [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 8'(i) ^ 8'hA5;
      gold[i] = 8'(i) ^ 8'hA5;
    end
    cpuout = 0;
    nReset = 1'b0; req = 2'b00; we = 2'b00;
    addr[0] = 0; addr[1] = 0; wd[0] = 0; wd[1] = 0;
    repeat (3) @(posedge CLK);
    #1 nReset = 1'b1;

    // store then load through requester 0
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, weg, ag, rdo, e);
    chk("t1_store_we", {31'd0, weg}, 32'd1);
    chk("t1_store_err", {31'd0, e}, 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, weg, ag, rdo, e);
    chk("t1_load_rdo", rdo, 32'hDEADBEEF);
    chk("t1_load_err", {31'd0, e}, 32'd0);

    // IO store and load through requester 1
    access(1, 1'b1, IO, 32'h5A, weg, ag, rdo, e);
    chk("io_we", {31'd0, weg}, 32'd1);
    chk("io_addr", ag, 32'h7FFFFFFC);
    chk("io_cpuout", cpuout, 32'h5A);
    chk("io_err", {31'd0, e}, 32'd0);
    access(1, 1'b0, IO, 32'h0, weg, ag, rdo, e);
    chk("io_load_rdo", rdo, 32'hC0FFEE01);

    // illegal stores must not reach memory
    access(0, 1'b1, 32'h13, 32'h11111111, weg, ag, rdo, e);
    chk("misal_we", {31'd0, weg}, 32'd0);
    chk("misal_err", {31'd0, e}, 32'd1);
    chk("misal_rdo", rdo, 32'd0);
    access(0, 1'b1, 32'h400, 32'h22222222, weg, ag, rdo, e);
    chk("oor_we", {31'd0, weg}, 32'd0);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_rdo", rdo, 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, weg, ag, rdo, e);
    chk("mem_intact", rdo, 32'hDEADBEEF);
    access(1, 1'b0, 32'h3FC, 32'h0, weg, ag, rdo, e);
    chk("top_word", rdo, 32'h5A5B5859);

    // simultaneous requests out of reset: 0 first, 1 two cycles later
    do_reset();
    @(posedge CLK); #1;
    req = 2'b11; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h20;
    seen = 0; g0_cyc = 0; g1_cyc = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (gnt[0]) begin seen = 1; g0_cyc = cyc; end
    end
    chk("tie_gnt0_first", {31'd0, seen && !gnt[1]}, 32'd1);
    @(posedge CLK); #1 req[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (gnt[1]) begin seen = 1; g1_cyc = cyc; end
    end
    chk("tie_gnt1_seen", {31'd0, seen}, 32'd1);
    chk("tie_gnt1_delay", 32'(g1_cyc - g0_cyc), 32'd2);
    @(posedge CLK); #1 req[1] = 1'b0;
    repeat (2) @(negedge CLK);

    // both held continuously: bursts of four
    do_reset();
    @(posedge CLK); #1;
    req = 2'b11; we = 2'b00; addr[0] = 32'h40; addr[1] = 32'h80;
    for (int i = 0; i < 40 && order.size() < 9; i++) begin
      @(negedge CLK);
      if (gnt[0]) order.push_back(0);
      if (gnt[1]) order.push_back(1);
    end
    @(posedge CLK); #1 req = 2'b00;
    chk("burst_count", 32'(order.size()), 32'd9);
    for (int i = 0; i < 9 && i < order.size(); i++)
      chk($sformatf("burst_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
    repeat (3) @(negedge CLK);

    // reset in the SERVE cycle of a store aborts it
    @(posedge CLK); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'hCAFEF00D;
    @(posedge CLK); #2;
    nReset = 1'b0;
    #1;
    chk("rst_we_low", {31'd0, WE}, 32'd0);
    chk("rst_gnt_low", {30'd0, gnt}, 32'd0);
    @(posedge CLK); #1 req = 2'b00;
    @(posedge CLK); #1 nReset = 1'b1;
    @(negedge CLK);
    chk("rst_no_rvalid", {30'd0, rvalid}, 32'd0);
    access(0, 1'b0, 32'h20, 32'h0, weg, ag, rdo, e);
    chk("rst_mem_unchanged", rdo, 32'h86878485);
    access(1, 1'b1, 32'h20, 32'h12345678, weg, ag, rdo, e);
    chk("post_rst_store_err", {31'd0, e}, 32'd0);
    access(0, 1'b0, 32'h20, 32'h0, weg, ag, rdo, e);
    chk("post_rst_load", rdo, 32'h12345678);

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
